// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: write-mode
// encodings, default geometry and the 16-entry power-on register image.
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 16;
  localparam int DEFAULT_NUM_REGS = 16;
  localparam int RESET_TABLE_LEN  = 16;

  // reg_write encodings
  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_GEN  = 2'b01;
  localparam logic [1:0] WR_R0   = 2'b10;
  localparam logic [1:0] WR_BOTH = 2'b11;

  // Reset image for registers 0..15; higher registers reset to zero.
  localparam logic [15:0] RESET_VALUES [RESET_TABLE_LEN] = '{
    16'h0000, 16'h7B18, 16'h245B, 16'hFF0F,
    16'hF0FF, 16'h0051, 16'h6666, 16'h00FF,
    16'hFF88, 16'h0000, 16'h0000, 16'h3099,
    16'hCCCC, 16'h0002, 16'h0011, 16'h0000
  };

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: claims set busy bits, committed writes clear
// them, and a claim against an already-busy register raises a one-cycle
// claim_err pulse. Also provides the busy view for the two read ports and R0.
// Optional macro REGFILE_BYPASS_EN: busy views reflect same-cycle clears.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        reg_write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic              busy1,
  output logic              busy2,
  output logic              r0_busy,
  output logic              claim_err
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                claim_err_q;
  logic                claim_err_d;
  logic [NUM_REGS-1:0] clear_s;
  logic [NUM_REGS-1:0] claim_s;
  logic [NUM_REGS-1:0] busy_view_s;

  // Decode which registers this cycle's writes clear and which one is claimed.
  always_comb begin
    clear_s = '0;
    claim_s = '0;
    case (reg_write)
      WR_GEN:  clear_s[write_addr] = 1'b1;
      WR_R0:   clear_s[0] = 1'b1;
      WR_BOTH: begin
        clear_s[0]          = 1'b1;
        clear_s[write_addr] = 1'b1;
      end
      default: clear_s = '0;
    endcase
    if (claim_valid) begin
      claim_s[claim_addr] = 1'b1;
    end else begin
      claim_s = '0;
    end
  end

  // Next busy state: a claim beats a clear so a new producer stays tracked.
  always_comb begin
    busy_d      = (busy_q & ~clear_s) | claim_s;
    claim_err_d = claim_valid & busy_q[claim_addr];
  end

  // Busy state and error pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q      <= '0;
      claim_err_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      claim_err_q <= claim_err_d;
    end
  end

  // Busy view presented to decode; with bypass a same-cycle clear shows early.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    busy_view_s = busy_q & ~(clear_s & ~claim_s);
`else
    busy_view_s = busy_q;
`endif
  end

  assign busy1     = busy_view_s[read_addr1];
  assign busy2     = busy_view_s[read_addr2];
  assign r0_busy   = busy_view_s[0];
  assign claim_err = claim_err_q;

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: two asynchronous read ports plus an R0 read,
// a general write port plus an R0 write port, and a busy scoreboard.
// Optional macro REGFILE_BYPASS_EN: reads forward same-cycle write data.
module param_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        reg_write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] r0_write_data,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] r0_read_data,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              r0_busy,
  output logic              claim_err
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Reset image entry for register idx, resized to DATA_W.
  function automatic logic [DATA_W-1:0] reset_value(input int idx);
    logic [DATA_W-1:0] v;
    v = '0;
    if (idx < RESET_TABLE_LEN) begin
      v = DATA_W'(RESET_VALUES[idx[3:0]]);
    end else begin
      v = '0;
    end
    return v;
  endfunction

  // Next register contents; the general port is applied last so it wins on R0.
  always_comb begin
    regs_d = regs_q;
    case (reg_write)
      WR_GEN:  regs_d[write_addr] = write_data;
      WR_R0:   regs_d[0] = r0_write_data;
      WR_BOTH: begin
        regs_d[0]          = r0_write_data;
        regs_d[write_addr] = write_data;
      end
      default: regs_d = regs_q;
    endcase
  end

  // Register storage with synchronous active-low reset to the reset image.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= reset_value(i);
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes; with bypass the next-state image already carries the forward.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    read_data1   = regs_d[read_addr1];
    read_data2   = regs_d[read_addr2];
    r0_read_data = regs_d[0];
`else
    read_data1   = regs_q[read_addr1];
    read_data2   = regs_q[read_addr2];
    r0_read_data = regs_q[0];
`endif
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .reg_write   (reg_write),
    .write_addr  (write_addr),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .read_addr1  (read_addr1),
    .read_addr2  (read_addr2),
    .busy1       (busy1),
    .busy2       (busy2),
    .r0_busy     (r0_busy),
    .claim_err   (claim_err)
  );

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor of the 16x16 CPU register file.
- Provides a configurable number of registers and data width, two asynchronous read ports plus a dedicated R0 (accumulator) read, and a general write port plus a dedicated R0 write port.
- Adds a per-register busy scoreboard so multi-cycle units (multiply/divide writing R0 and Rn) can claim destinations, and the decode stage can detect hazards.
- Sits between decode (reads, claims) and writeback (writes).

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 16, number of registers; power of two, at least 2.
- ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- reg_write  in  2  write mode: 00 none, 01 general port, 10 R0 port, 11 both.
- write_addr  in  ADDR_W  general write destination.
- write_data  in  DATA_W  general write data.
- r0_write_data  in  DATA_W  R0 port write data.
- read_addr1  in  ADDR_W  read port 1 address.
- read_addr2  in  ADDR_W  read port 2 address.
- read_data1  out  DATA_W  register[read_addr1].
- read_data2  out  DATA_W  register[read_addr2].
- r0_read_data  out  DATA_W  register[0].
- claim_valid  in  1  mark claim_addr busy (destination issued to a multi-cycle unit).
- claim_addr  in  ADDR_W  register being claimed.
- busy1  out  1  busy bit of read_addr1.
- busy2  out  1  busy bit of read_addr2.
- r0_busy  out  1  busy bit of register 0.
- claim_err  out  1  registered one-cycle pulse: a claim targeted an already-busy register.

Behaviour:
- Reset (reset_n low at rising edge):
  - Registers load the package constant RESET_VALUES.
  - Index i < 16 takes table entry i truncated/zero-extended to DATA_W; i >= 16 loads 0.
  - All busy bits clear; claim_err = 0.
  - Reset has priority over writes and claims in the same cycle.
  - Combinational outputs reflect reset contents from the next cycle.
- Reset table (16-bit): 0000 7B18 245B FF0F F0FF 0051 6666 00FF FF88 0000 0000 3099 CCCC 0002 0011 0000.
- Writes:
  - Mode 01 writes write_data to write_addr.
  - Mode 10 writes r0_write_data to register 0.
  - Mode 11 performs both.
  - If mode 11 and write_addr == 0, the general port wins and write_data is stored.
  - Register 0 is a normal writable register, not hard-wired to zero.
- Reads:
  - read_data1, read_data2, r0_read_data and busy1/busy2/r0_busy are combinational from current state.
  - A written value is visible the cycle after the write edge (unless bypass is enabled, see Optional Feature).
  - Both read ports may address the same register.
- Scoreboard: one busy bit per register.
  - A committed write (via either port) to register k clears busy[k] at that edge.
  - claim_valid sets busy[claim_addr].
  - Same-cycle claim and write to the same register: claim wins, busy stays 1 (new producer issued).
  - Mode 11 clears busy[write_addr] and busy[0].
  - Writes to non-busy registers are legal and leave the busy bit 0.
- claim_err:
  - Registered; asserts for exactly one cycle after a claim to a register whose busy bit was already 1 before that edge.
  - busy stays 1 in that case.
  - claim_err does not block the write path.
- No stalls generated internally; the consumer uses busy flags.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Each read output (read_data1, read_data2, r0_read_data) forwards same-cycle write data when its address matches an active write. Port priority follows the write rule (general over R0).
  - busyN reads 0 when a same-cycle write to that address clears it and no same-cycle claim targets it.
- Undefined: reads return stored state only; one-cycle write-to-read latency.

Decomposition:
- Package regfile_pkg holds:
  - the reg_write encoding constants (WR_NONE, WR_GEN, WR_R0, WR_BOTH);
  - the 16-entry RESET_VALUES table;
  - the default DATA_W/NUM_REGS.
- One natural sub-module: regfile_scoreboard, containing the busy vector, the claim/clear logic and claim_err, with the read-port busy muxes.
- Storage and read muxes stay in the top module.

Test Plan:
- Reset, then read R1/R2/R0 -> read_data1=7B18, read_data2=245B, r0_read_data=0000, all busy=0, claim_err=0.
- Mode 11, write_addr=5, write_data=1234, r0_write_data=ABCD; next cycle read R5/R0 -> 1234/ABCD. Repeat with write_addr=0 -> R0=1234.
- claim R3, then wait 2 cycles -> busy=1 when read_addr1=3. Mode 01 write R3=0F0F -> busy clears next cycle, data 0F0F.
- Claim R3 while busy -> claim_err high exactly one cycle, busy stays 1. Same-cycle claim+write R7 -> data written, busy[7]=1.
- reset_n low mid-sequence with a mode-11 write and a claim active -> reset values restored, busy all 0, write discarded.
- With REGFILE_BYPASS_EN: write R9=BEEF while read_addr2=9 -> read_data2=BEEF in the same cycle. Without the macro, read_data2=0000 then BEEF the next cycle.
